data_mem_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: port 0 is the CPU load/store stage
//  and port 1 is the debug/DMA loader. Each port uses a req/ack handshake. Simultaneous requests
//  are arbitered round-robin. One access is sequenced at a time onto the memory AddrIn/Din/WE/DOut

---
 rtl/data_mem_arbiter.sv | 130 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU (port 0)
// and the debug/DMA loader (port 1); one access at a time, three cycles each.
//
// state    | meaning
// S_IDLE   | waiting for a request; latches the granted port's access
// S_ACCESS | access on the memory pins; write commits / read captured at the end
// S_DONE   | ack, rdata and err presented to the granted port for one cycle
module data_mem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MEM_DEPTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    output logic          err0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic          err1,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout,
    output logic          busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [AW-1:0] DEPTH_A = AW'(MEM_DEPTH);

    logic [1:0]    state_q,    state_d;
    logic          last_gnt_q, last_gnt_d;
    logic          sel_q,      sel_d;
    logic          we_q,       we_d;
    logic [AW-1:0] addr_q,     addr_d;
    logic [DW-1:0] wdata_q,    wdata_d;
    logic [DW-1:0] rdata_q,    rdata_d;
    logic          mem_we_q,   mem_we_d;
    logic          grant;
    logic          in_range;
    logic          done;

    assign in_range = (addr_q < DEPTH_A);
    assign done     = (state_q == S_DONE);

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        sel_d      = sel_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        mem_we_d   = 1'b0;
        grant      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // on a conflict the port that did not win last time goes first
                    grant      = (req0 && req1) ? ~last_gnt_q : req1;
                    sel_d      = grant;
                    we_d       = grant ? we1    : we0;
                    addr_d     = grant ? addr1  : addr0;
                    wdata_d    = grant ? wdata1 : wdata0;
                    last_gnt_d = grant;
                    mem_we_d   = we_d && (addr_d < DEPTH_A);
                    state_d    = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!we_q) begin
                    rdata_d = in_range ? mem_dout : '0;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            last_gnt_q <= 1'b1;
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            mem_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            mem_we_q   <= mem_we_d;
        end
    end

    assign mem_addr = addr_q;
    assign mem_din  = wdata_q;
    assign mem_we   = mem_we_q;
    assign busy     = (state_q != S_IDLE);

    assign ack0   = done && !sel_q;
    assign ack1   = done &&  sel_q;
    assign err0   = ack0 && !in_range;
    assign err1   = ack1 && !in_range;
    assign rdata0 = ack0 ? rdata_q : '0;
    assign rdata1 = ack1 ? rdata_q : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a negedge-updated memory model, per-port requester tasks
// pushing expected responses, and an ack monitor that pops and compares them.
module tb_data_mem_arbiter;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        ack0, err0, ack1, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic        mem_we, busy;

    logic [31:0] mem [0:31];
    int          cyc    = 0;
    int          we_cnt = 0;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    int          ack_log[$];
    int          ack_cyc[$];

    always #5 clk = ~clk;

    data_mem_arbiter #(.AW(32), .DW(32), .MEM_DEPTH(32)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rdata0(rdata0), .err0(err0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1), .err1(err1),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_dout(mem_dout), .busy(busy)
    );

    // Memory model: write on posedge, read data refreshed on negedge.
    always @(posedge clk) begin
        if (mem_we && mem_addr < 32) mem[mem_addr[4:0]] <= mem_din;
    end
    always @(negedge clk) begin
        mem_dout <= (mem_addr < 32) ? mem[mem_addr[4:0]] : 32'hBAD0_BAD0;
        if (mem_we) we_cnt <= we_cnt + 1;
    end
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] <= 32'hA000_0000 + i;
        mem[3] <= 32'h0000_0011;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon_ack(input int p);
        exp_t e;
        int   qs;
        logic oth;
        qs = (p == 0) ? q0.size() : q1.size();
        chk($sformatf("p%0d_ack_expected", p), (qs > 0), 1);
        ack_log.push_back(p);
        ack_cyc.push_back(cyc);
        if (qs == 0) return;
        e = (p == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("p%0d_err", p), (p == 0) ? err0 : err1, e.err);
        if (e.chk_rd) chk($sformatf("p%0d_rdata", p), (p == 0) ? rdata0 : rdata1, e.rdata);
        oth = (p == 0) ? (ack1 | err1 | (rdata1 != 0)) : (ack0 | err0 | (rdata0 != 0));
        chk($sformatf("p%0d_other_port_quiet", p), oth, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (ack0 && ack1) chk("ack_overlap", 1, 0);
            if (ack0) mon_ack(0);
            else if (ack1) mon_ack(1);
        end
    end

    // Issue one access and hold req until the clock after ack.
    task automatic xfer(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err, output int lat);
        exp_t e;
        int   n, t0;
        logic seen;
        e.rdata = exp_rd; e.err = exp_err; e.chk_rd = !w;
        if (p == 0) begin
            q0.push_back(e); req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            q1.push_back(e); req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
        end
        t0 = cyc;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            seen = (p == 0) ? ack0 : ack1;
        end while (!seen && n < 40);
        if (!seen) chk($sformatf("p%0d_ack_timeout", p), 0, 1);
        lat = cyc - t0;
        @(posedge clk); #1;
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    int lat, lat_b, wc, n;

    initial begin
        reset = 1'b1;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        repeat (3) @(negedge clk);
        // outputs during and right after reset
        chk("rst_busy", busy, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_din", mem_din, 0);
        chk("rst_acks", {ack0, ack1, err0, err1}, 0);
        chk("rst_rdata", rdata0 | rdata1, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // P0 write then read of addr 5; ack lands in the third cycle counted from the raise
        wc = we_cnt;
        xfer(0, 1, 32'd5, 32'hDEAD_BEEF, 0, 0, lat);
        chk("p0_first_grant_lat", lat, 2);
        chk("write_we_cycles", we_cnt - wc, 1);
        xfer(0, 0, 32'd5, 0, 32'hDEAD_BEEF, 0, lat);
        chk("read_ack_lat", lat, 2);

        // range boundary
        xfer(0, 0, 32'd31, 0, 32'hA000_001F, 0, lat);
        wc = we_cnt;
        xfer(0, 1, 32'd32, 32'h1234_5678, 0, 1, lat);
        chk("oor32_no_we", we_cnt - wc, 0);
        wc = we_cnt;
        xfer(1, 1, 32'd40, 32'h1234_5678, 0, 1, lat);
        chk("oor40_no_we", we_cnt - wc, 0);
        xfer(1, 0, 32'd40, 0, 32'h0, 1, lat);

        // conflict: both held; last grant was port 1, so P0 first
        ack_log.delete(); ack_cyc.delete();
        fork
            begin
                xfer(0, 0, 32'd7, 0, 32'hA000_0007, 0, lat);
                xfer(0, 0, 32'd8, 0, 32'hA000_0008, 0, lat);
            end
            begin
                xfer(1, 0, 32'd9, 0, 32'hA000_0009, 0, lat_b);
                xfer(1, 0, 32'd10, 0, 32'hA000_000A, 0, lat_b);
            end
        join
        chk("rr_count", ack_log.size(), 4);
        if (ack_log.size() == 4) begin
            chk("rr_order", {ack_log[0][7:0], ack_log[1][7:0], ack_log[2][7:0], ack_log[3][7:0]},
                32'h00010001);
            for (int i = 1; i < 4; i++) chk($sformatf("rr_spacing_%0d", i), ack_cyc[i] - ack_cyc[i-1], 3);
        end

        // reset during the ACCESS of a write to addr 3
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd3; wdata0 = 32'h55;
        @(posedge clk); #2;
        chk("abort_busy_pre", busy, 1);
        chk("abort_we_pre", mem_we, 1);
        chk("abort_addr_pre", mem_addr, 3);
        reset = 1'b1;
        #1;
        chk("abort_we_drop", mem_we, 0);
        chk("abort_busy_drop", busy, 0);
        chk("abort_ack", ack0, 0);
        req0 = 1'b0; we0 = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        xfer(0, 0, 32'd3, 0, 32'h0000_0011, 0, lat);

        // P1 streams; P0 joins after P1's first ack and is served in the next IDLE
        ack_log.delete(); ack_cyc.delete();
        fork
            begin
                xfer(1, 0, 32'd10, 0, 32'hA000_000A, 0, lat_b);
                xfer(1, 0, 32'd11, 0, 32'hA000_000B, 0, lat_b);
                xfer(1, 0, 32'd12, 0, 32'hA000_000C, 0, lat_b);
            end
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (!ack1 && n < 40);
                if (!ack1) chk("stream_first_ack_timeout", 0, 1);
                @(posedge clk); #1;
                xfer(0, 0, 32'd20, 0, 32'hA000_0014, 0, lat);
                chk("stream_p0_lat", lat, 2);
            end
        join
        chk("stream_count", ack_log.size(), 4);
        if (ack_log.size() == 4)
            chk("stream_order", {ack_log[0][7:0], ack_log[1][7:0], ack_log[2][7:0], ack_log[3][7:0]},
                32'h01000101);

        repeat (3) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
